enemy_missile_launcher: RTL

ENEMY_MISSILE_LAUNCHER -- requirements
Module: enemy_missile_launcher

---
 rtl/enemy_missile_pkg.sv | 36 +++
 rtl/missile_dda_stepper.sv | 67 ++++++
 rtl/enemy_missile_launcher.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/enemy_missile_pkg.sv
// Shared definitions for the enemy missile launcher, its targeting register and
// the collision logic: state encoding, coordinate widths and default geometry.
package enemy_missile_pkg;

    localparam int COORD_W     = 10;
    localparam int ERR_W       = 11;
    localparam int NUM_TARGETS = 3;

    localparam logic [COORD_W-1:0] DEF_START_X  = 10'd320;
    localparam logic [COORD_W-1:0] DEF_START_Y  = 10'd0;
    localparam logic [COORD_W-1:0] DEF_GROUND_Y = 10'd440;
    localparam logic [COORD_W-1:0] DEF_TGT_X0   = 10'd80;
    localparam logic [COORD_W-1:0] DEF_TGT_X1   = 10'd320;
    localparam logic [COORD_W-1:0] DEF_TGT_X2   = 10'd560;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_FLY    = 2'd2,
        ST_IMPACT = 2'd3
    } launcher_state_e;

    function automatic logic [COORD_W-1:0] abs_diff(
        input logic [COORD_W-1:0] a,
        input logic [COORD_W-1:0] b
    );
        logic [COORD_W-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

endpackage

// File: rtl/missile_dda_stepper.sv
// Horizontal DDA for the missile: one vertical pixel per step, x advancing by at
// most one pixel toward the target so the path lands exactly on it.
module missile_dda_stepper
    import enemy_missile_pkg::*;
#(
    parameter logic [COORD_W-1:0] START_X = DEF_START_X,
    parameter logic [COORD_W-1:0] DY      = DEF_GROUND_Y - DEF_START_Y
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [COORD_W-1:0] tgt_x,
    output logic [COORD_W-1:0] x
);

    localparam logic [ERR_W-1:0] DY_ERR = {{(ERR_W-COORD_W){1'b0}}, DY};
    localparam logic [ERR_W:0]   DY_EXT = {1'b0, DY_ERR};

    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] dx_r;
    logic               dir_up_r;
    logic [ERR_W-1:0]   err_r;

    logic [ERR_W:0]     sum_s;
    logic               take_step_s;
    logic [ERR_W-1:0]   err_next_s;

    // Step decision: err stays below DY, so the sum never overflows ERR_W+1 bits
    always_comb begin
        sum_s = {1'b0, err_r} + {{(ERR_W+1-COORD_W){1'b0}}, dx_r};
        if (sum_s >= DY_EXT) begin
            take_step_s = 1'b1;
            err_next_s  = sum_s[ERR_W-1:0] - DY_ERR;
        end else begin
            take_step_s = 1'b0;
            err_next_s  = sum_s[ERR_W-1:0];
        end
    end

    // Trajectory registers: loaded when arming, advanced once per accepted tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r      <= START_X;
            dx_r     <= {COORD_W{1'b0}};
            dir_up_r <= 1'b0;
            err_r    <= {ERR_W{1'b0}};
        end else if (load) begin
            x_r      <= START_X;
            dx_r     <= abs_diff(tgt_x, START_X);
            dir_up_r <= (tgt_x >= START_X);
            err_r    <= {ERR_W{1'b0}};
        end else if (step) begin
            err_r <= err_next_s;
            if (take_step_s) begin
                x_r <= dir_up_r ? (x_r + 10'd1) : (x_r - 10'd1);
            end else begin
                x_r <= x_r;
            end
        end else begin
            x_r <= x_r;
        end
    end

    assign x = x_r;

endmodule

// File: rtl/enemy_missile_launcher.sv
// Enemy missile launcher: accepts a launch toward one of three ground targets,
// flies the missile one scanline per frame and reports impact or interception.
module enemy_missile_launcher
    import enemy_missile_pkg::*;
#(
    parameter logic [COORD_W-1:0] START_X  = DEF_START_X,
    parameter logic [COORD_W-1:0] START_Y  = DEF_START_Y,
    parameter logic [COORD_W-1:0] GROUND_Y = DEF_GROUND_Y,
    parameter logic [COORD_W-1:0] TGT_X0   = DEF_TGT_X0,
    parameter logic [COORD_W-1:0] TGT_X1   = DEF_TGT_X1,
    parameter logic [COORD_W-1:0] TGT_X2   = DEF_TGT_X2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               launch_req,
    input  logic [2:0]         target_in,
    input  logic               destroyed,
    output logic [COORD_W-1:0] missile_x,
    output logic [COORD_W-1:0] missile_y,
    output logic               active,
    output logic               busy,
    output logic [1:0]         target_id,
    output logic               impact,
    output logic               reject
);

    launcher_state_e    state_r;
    launcher_state_e    state_next_s;
    logic [COORD_W-1:0] y_r;
    logic [COORD_W-1:0] x_s;
    logic [COORD_W-1:0] tgt_x_s;
    logic [1:0]         target_id_r;
    logic               active_r;
    logic               busy_r;
    logic               impact_r;
    logic               reject_r;

    logic               valid_tgt_s;
    logic               accept_s;
    logic               refuse_s;
    logic               load_s;
    logic               step_s;
    logic               ground_s;

    // Launch decode and per-tick flight control strobes
    always_comb begin
        valid_tgt_s = (target_in < 3'(NUM_TARGETS));
        accept_s    = (state_r == ST_IDLE) && launch_req && valid_tgt_s;
        refuse_s    = (state_r == ST_IDLE) && launch_req && !valid_tgt_s;
        load_s      = (state_r == ST_ARM);
        step_s      = (state_r == ST_FLY) && frame_tick && !destroyed;
        ground_s    = ((y_r + 10'd1) == GROUND_Y);
    end

    // Next-state logic; interception takes priority over reaching the ground
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_ARM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                state_next_s = ST_FLY;
            end
            ST_FLY: begin
                if (destroyed) begin
                    state_next_s = ST_IDLE;
                end else if (step_s && ground_s) begin
                    state_next_s = ST_IMPACT;
                end else begin
                    state_next_s = ST_FLY;
                end
            end
            ST_IMPACT: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Target x lookup for the latched target index
    always_comb begin
        case (target_id_r)
            2'd0:    tgt_x_s = TGT_X0;
            2'd1:    tgt_x_s = TGT_X1;
            2'd2:    tgt_x_s = TGT_X2;
            default: tgt_x_s = START_X;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered status outputs, derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r      <= 1'b0;
            active_r    <= 1'b0;
            impact_r    <= 1'b0;
            reject_r    <= 1'b0;
            target_id_r <= 2'd0;
        end else begin
            busy_r   <= (state_next_s != ST_IDLE);
            active_r <= (state_next_s == ST_FLY) || (state_next_s == ST_IMPACT);
            impact_r <= (state_next_s == ST_IMPACT);
            reject_r <= refuse_s;
            if (accept_s) begin
                target_id_r <= target_in[1:0];
            end else begin
                target_id_r <= target_id_r;
            end
        end
    end

    // Vertical position: one scanline per accepted frame tick, held while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_r <= START_Y;
        end else if (load_s) begin
            y_r <= START_Y;
        end else if (step_s) begin
            y_r <= y_r + 10'd1;
        end else begin
            y_r <= y_r;
        end
    end

    missile_dda_stepper #(
        .START_X (START_X),
        .DY      (GROUND_Y - START_Y)
    ) u_stepper (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .step  (step_s),
        .tgt_x (tgt_x_s),
        .x     (x_s)
    );

    assign missile_x = x_s;
    assign missile_y = y_r;
    assign active    = active_r;
    assign busy      = busy_r;
    assign target_id = target_id_r;
    assign impact    = impact_r;
    assign reject    = reject_r;

endmodule
